data_memory_bank: RTL
=====================

# data_memory_bank

Byte-addressable RISC-V data memory with a valid/ready request port, RV32I load/store width handling, and registered responses. It replaces the word-only, combinational-read data memory in the load/store path. Also added: byte/halfword lanes, sign extension, misalignment and range faults, and a sequential clear after reset in place of a one-cycle array reset. It sits between the core's ALU/LSU stage and the writeback mux.

## Interface
- `ADDR_WIDTH`, default 32: request byte-address width.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, at least 2.
- `INIT_CLEAR`, default 1: 1 clears the array after reset; 0 skips straight to RUN, leaving contents undefined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; a request is accepted when `req_valid` and `req_ready` are both high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle pulse, one per accepted request.
- `rsp_rdata` out 32: load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err` out 1: request faulted; valid with `rsp_valid`.
- `init_busy` out 1: clear sequence in progress.

## Operation
- State machine, two states:
  - INIT: entered on reset when `INIT_CLEAR`=1. Writes word `clr_idx` to 0 each cycle. `clr_idx` runs 0 to DEPTH_WORDS-1. Moves to RUN after the last word.
  - RUN: `req_ready`=1 every cycle; no back-pressure.
- Word index = `req_addr[$clog2(DEPTH_WORDS)+1:2]`; lane = `req_addr[1:0]`.
- Error conditions (no array write, `rsp_rdata`=0, `rsp_err`=1):
  - Out of range: `req_addr` ≥ 4·DEPTH_WORDS.
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- Stores:
  - SB writes byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`·2, +1} with `wdata[15:0]`.
  - SW writes all four lanes.
  - Unselected bytes are unchanged.
- Loads:
  - Read the word, select the lane, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- Ordering: requests complete in order. A load accepted the cycle after a store to the same address returns the stored data.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- `init_busy` resets to 1 if `INIT_CLEAR`=1, else 0.
- `clr_idx` resets to 0.
- Clear length: after `rst` falls, INIT lasts exactly DEPTH_WORDS cycles. `req_ready` rises in the cycle after the final clear write, together with `init_busy` falling.
- Response latency: request accepted at edge N → `rsp_valid`/`rsp_rdata`/`rsp_err` valid during the cycle after edge N, for exactly one cycle.
- Throughput: one request per cycle; back-to-back requests give a `rsp_valid` pulse on every cycle.
- `req_valid` while `req_ready`=0: ignored, no response.
- `rst` asserted mid-operation: in-flight response dropped (`rsp_valid`→0 immediately, asynchronously); FSM returns to INIT (or RUN) with `clr_idx`=0.
- `clr_idx` width is `$clog2(DEPTH_WORDS)`. The terminal check is `clr_idx==DEPTH_WORDS-1`, so there is no wrap.

## Structure
- Package `dmem_pkg` holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: ST_INIT, ST_RUN.
  - a byte-enable function.
  - a load-extend function.
- Sub-module `dmem_byte_array` (DEPTH_WORDS×32, 4-bit byte write enable, synchronous write, registered read, no reset on storage).
- Top level holds the FSM, clear counter, address decode/fault logic, write-data lane replication, and response registers.

## Test plan
- Reset with DEPTH_WORDS=16, then poll → `init_busy` high for 16 cycles; `req_ready` rises on cycle 17; LW 0x3C returns 0x00000000.
- SW 0x8 = 0xDEADBEEF, then SB 0x9 = 0x12 → LW 0x8 = 0xDEAD12EF, LB 0xB = 0xFFFFFFDE, LBU 0xB = 0x000000DE, LH 0xA = 0xFFFFDEAD.
- LH 0x5, LW 0x6, SW 0x40 (DEPTH_WORDS=16), load funct3=011 → each gives `rsp_err`=1 and `rsp_rdata`=0, with the target word unchanged.
- Back-to-back SW 0x0 = 0x11223344 then LW 0x0 on consecutive cycles → `rsp_valid` on two consecutive cycles; the load returns 0x11223344.
- Assert `rst` while a load response is pending → `rsp_valid` drops immediately; INIT restarts, and the previously written word reads 0 afterwards.

Source files
------------

// File: rtl/data_memory_bank_pkg.sv
// Package for the data memory bank.
// Contents:
//   - RV32I load/store funct3 encodings
//   - the control FSM state type
//   - a store byte-enable helper
//   - a load lane-select and extend helper
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Byte enables for a store.
    // The access size comes from funct3[1:0]. The lane comes from addr[1:0].
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte or halfword out of the read word.
    // Then sign- or zero-extend it according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'h0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// Request/response bus of the data memory bank.
// Request signals:
//   - req_valid/req_ready: accept handshake
//   - req_we, req_addr, req_funct3, req_wdata: request fields
// Response signals:
//   - rsp_valid: one-cycle response pulse
//   - rsp_rdata, rsp_err: response fields
// Status:
//   - init_busy: high while the post-reset clear is running
// The slave modport is the memory side; the master modport is the LSU side.
interface data_memory_bank_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_funct3;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  init_busy;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );
endinterface

// File: rtl/data_memory_bank_byte_array.sv
// Storage for the data memory: DEPTH_WORDS x 32 bits, organised as four byte lanes.
// Ports:
//   - clk:   write and read clock
//   - we:    per-lane write enable
//   - waddr: write word index
//   - wdata: write data
//   - re:    read enable
//   - raddr: read word index
//   - rdata: registered read data; holds its value while re is low
// The storage has no reset; the clear sequence in the top level zeroes it.
module dmem_byte_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[g]) mem[waddr] <= wdata[g*8 +: 8];
            if (re)    rd_q       <= mem[raddr];
        end

        assign rdata[g*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressable RV32I data memory.
// Ports:
//   - clk: clock
//   - rst: asynchronous, active-high reset
//   - bus: request/response bus (slave modport)
// Behaviour:
//   - After reset the array is optionally cleared, one word per cycle,
//     while init_busy is high.
//   - Once in RUN, one request is accepted per cycle.
//   - Each accepted request gets a one-cycle response in the cycle after acceptance.
//   - Faulting requests never touch the array. They respond with rsp_err=1 and rdata=0.
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    data_memory_bank_if.slave bus
);

    localparam int     IDX_W     = $clog2(DEPTH_WORDS);
    localparam state_e RST_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clr_we;

    // ---------------- FSM / clear counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_we = 1'b1;
                // Stop on the last index rather than wrapping, so the counter needs no extra bit.
                if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
                else                                      clr_idx_d = clr_idx_q + 1'b1;
            end
            ST_RUN:  ;
            default: state_d = RST_STATE;
        endcase
    end

    // Gate with rst so that ready reads 0 during reset even when no clear is configured.
    logic ready;
    assign ready         = (state_q == ST_RUN) && !rst;
    assign bus.req_ready = ready;
    assign bus.init_busy = (state_q == ST_INIT);

    // ---------------- Decode / fault ----------------
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             oor, f3_ok, misalign, req_err;
    logic             store_go, load_go;

    assign accept = bus.req_valid && ready;
    assign idx    = bus.req_addr[IDX_W+1:2];
    assign lane   = bus.req_addr[1:0];

    // Out of range is any address bit set above the word-index field.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
        assign oor = |bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    always_comb begin
        if (bus.req_we) f3_ok = bus.req_funct3 inside {F3_B, F3_H, F3_W};
        else            f3_ok = bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end

    assign misalign = ((bus.req_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    assign req_err  = oor || !f3_ok || misalign;
    assign store_go = accept &&  bus.req_we && !req_err;
    assign load_go  = accept && !bus.req_we && !req_err;

    // Store data is replicated across all lanes; the byte enables pick the live ones.
    logic [31:0] wdata_rep;
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
            default: wdata_rep = bus.req_wdata;
        endcase
    end

    // ---------------- Array ----------------
    // The clear port is used only in INIT and stores only in RUN, so they never collide.
    logic [3:0]       arr_we;
    logic [IDX_W-1:0] arr_waddr;
    logic [31:0]      arr_wdata;
    logic [31:0]      arr_rdata;

    assign arr_we    = clr_we ? 4'hF : (store_go ? byte_en(bus.req_funct3, lane) : 4'h0);
    assign arr_waddr = clr_we ? clr_idx_q : idx;
    assign arr_wdata = clr_we ? 32'h0 : wdata_rep;

    dmem_byte_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (load_go),
        .raddr (idx),
        .rdata (arr_rdata)
    );

    // ---------------- Response ----------------
    // The array read is registered. Only the request metadata is captured here.
    // Extension happens after the register.
    logic       rsp_vld_q, rsp_err_q, rsp_load_q;
    logic [2:0] rsp_f3_q;
    logic [1:0] rsp_lane_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
            rsp_f3_q   <= 3'b0;
            rsp_lane_q <= 2'b0;
        end else begin
            rsp_vld_q  <= accept;
            rsp_err_q  <= accept && req_err;
            rsp_load_q <= load_go;
            rsp_f3_q   <= bus.req_funct3;
            rsp_lane_q <= lane;
        end
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_vld_q && rsp_load_q) ? load_extend(rsp_f3_q, rsp_lane_q, arr_rdata)
                                                     : 32'h0;

endmodule
